// File: rtl/seq_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared constants for the pattern transmitter and the
//                board-level sequence detector display decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SETUP  = 3'd1;
    localparam logic [2:0] c_STROBE = 3'd2;
    localparam logic [2:0] c_GAP    = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    localparam int c_MAX_LEN = 8;
    localparam int c_LEN_W   = 4;

endpackage
`default_nettype wire

// File: rtl/seq_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen_if
//  Description : Control/data bundle between button logic and seq_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_gen_if
    import seq_pkg::*;
#(
    parameter int MAX_LEN = c_MAX_LEN
);
    logic                start;
    logic                abort;
    logic [MAX_LEN-1:0]  pattern;
    logic [c_LEN_W-1:0]  length;
    logic                bit_out;
    logic                step;
    logic                busy;
    logic                done;
    logic [2:0]          state_display;

    modport master (
        output start, abort, pattern, length,
        input  bit_out, step, busy, done, state_display
    );

    modport slave (
        input  start, abort, pattern, length,
        output bit_out, step, busy, done, state_display
    );
endinterface
`default_nettype wire

// File: rtl/seq_gen_edge_rise.sv
`default_nettype none
// ============================================================================
//  Module      : edge_rise
//  Description : Registered rising-edge detector, active-low sync reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise
);
    logic r_last;
    logic r_armed;

    // A level already high when reset releases must not count as an edge,
    // so an edge is only accepted after the input has been seen low once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_last <= i_d;
            if (!i_d) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_rise = i_d & ~r_last & r_armed;
endmodule
`default_nettype wire

// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen
//  Description : Bit-serial MSB-first pattern transmitter with step strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_gen
    import seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_LEN     = c_MAX_LEN
) (
    input  logic      clk,
    input  logic      reset,
    seq_gen_if.slave  bus
);
    localparam int c_CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_CW      = $clog2(c_CNT_MAX) + 1;
    localparam logic [c_CW-1:0]    c_HOLD_LD = c_CW'(HOLD_CYCLES - 1);
    localparam logic [c_CW-1:0]    c_GAP_LD  = c_CW'(GAP_CYCLES - 1);
    localparam logic [c_LEN_W-1:0] c_LEN_CAP = c_LEN_W'(MAX_LEN);

    logic [2:0]          r_state;
    logic [MAX_LEN-1:0]  r_pat;
    logic [c_LEN_W-1:0]  r_idx;
    logic [c_CW-1:0]     r_cnt;
    logic                r_bit;

    logic                w_trig;
    logic [c_LEN_W-1:0]  w_len;
    logic [c_LEN_W-1:0]  w_len_m1;
    logic [c_LEN_W-1:0]  w_idx_m1;
    logic [MAX_LEN-1:0]  w_pat_first;
    logic [MAX_LEN-1:0]  w_pat_next;

    edge_rise u_start_edge (
        .clk    (clk),
        .reset  (reset),
        .i_d    (bus.start),
        .o_rise (w_trig)
    );

    always_comb begin
        w_len       = (bus.length > c_LEN_CAP) ? c_LEN_CAP : bus.length;
        w_len_m1    = w_len - c_LEN_W'(1);
        w_idx_m1    = r_idx - c_LEN_W'(1);
        w_pat_first = bus.pattern >> w_len_m1;
        w_pat_next  = r_pat >> w_idx_m1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_pat   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_bit   <= 1'b0;
        end else if (bus.abort) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_bit   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_trig) begin
                        r_pat <= bus.pattern;
                        r_idx <= w_len_m1;
                        if (w_len == '0) begin
                            r_state <= c_DONE;
                        end else begin
                            r_state <= c_SETUP;
                            r_bit   <= w_pat_first[0];
                        end
                    end
                end
                c_SETUP: begin
                    r_state <= c_STROBE;
                    r_cnt   <= c_HOLD_LD;
                end
                c_STROBE: begin
                    if (r_cnt == '0) begin
                        r_state <= c_GAP;
                        r_cnt   <= c_GAP_LD;
                    end else begin
                        r_cnt <= r_cnt - c_CW'(1);
                    end
                end
                c_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CW'(1);
                    end else if (r_idx == '0) begin
                        r_state <= c_DONE;
                        r_bit   <= 1'b0;
                    end else begin
                        r_state <= c_SETUP;
                        r_idx   <= w_idx_m1;
                        r_bit   <= w_pat_next[0];
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_bit   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bit_out       = r_bit;
    assign bus.step          = (r_state == c_STROBE);
    assign bus.busy          = (r_state == c_SETUP) || (r_state == c_STROBE) || (r_state == c_GAP);
    assign bus.done          = (r_state == c_DONE);
    assign bus.state_display = r_state;
endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_gen
//  Description : Directed self-checking bench for seq_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_gen;
    logic clk;
    logic reset;

    seq_gen_if #(.MAX_LEN(8)) bus ();

    seq_gen #(
        .HOLD_CYCLES (2),
        .GAP_CYCLES  (2),
        .MAX_LEN     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int          res_steps;
    logic [15:0] res_bits;
    int          res_busy;
    int          res_done_at;
    int          res_step_hi;
    int          res_hold_err;
    logic        res_first_bit;
    logic [2:0]  res_first_state;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {bus.state_display, bus.step, bus.bit_out, bus.done, bus.busy};
    endfunction

    // Called in the trigger cycle T; returns in the IDLE cycle after done.
    task automatic run_transfer(input logic [7:0] pat, input logic [3:0] len,
                                input bit hold_start, input int budget);
        logic prev_step;
        logic prev_bit;
        bus.pattern = pat;
        bus.length  = len;
        bus.start   = 1'b1;
        res_steps = 0; res_bits = '0; res_busy = 0; res_done_at = -1;
        res_step_hi = 0; res_hold_err = 0; res_first_bit = 1'b0; res_first_state = 3'd0;
        prev_step = 1'b0;
        prev_bit  = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (!hold_start) bus.start = 1'b0;
            if (k == 1) begin
                res_first_bit   = bus.bit_out;
                res_first_state = bus.state_display;
            end
            if (bus.step && !prev_step) begin
                res_steps++;
                res_bits = {res_bits[14:0], bus.bit_out};
            end
            if (bus.step && prev_step && (bus.bit_out != prev_bit)) res_hold_err++;
            if (bus.step) res_step_hi++;
            if (bus.busy) res_busy++;
            if (bus.done && res_done_at < 0) res_done_at = k;
            prev_step = bus.step;
            prev_bit  = bus.bit_out;
            if (res_done_at >= 0 && k > res_done_at) break;
        end
    endtask

    initial begin
        int seen;
        bus.start   = 1'b1;
        bus.abort   = 1'b0;
        bus.pattern = '0;
        bus.length  = '0;
        reset       = 1'b0;

        // reset held with start high
        repeat (3) tick();
        check("reset_outputs", outs(), 7'd0);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.busy || bus.done || bus.step) seen = 1;
        end
        check("reset_no_retrigger", seen, 0);
        bus.start = 1'b0;
        repeat (2) tick();

        // 3-bit pattern 0,1,0
        run_transfer(8'b0000_0010, 4'd3, 1'b0, 40);
        check("a_first_state", res_first_state, 3'd1);
        check("a_steps", res_steps, 3);
        check("a_bits", res_bits, 16'b010);
        check("a_step_hi", res_step_hi, 6);
        check("a_busy", res_busy, 15);
        check("a_done_at", res_done_at, 16);
        check("a_hold", res_hold_err, 0);
        check("a_idle_after", outs(), 7'd0);

        // length clamp, start held high throughout
        run_transfer(8'hFF, 4'd12, 1'b1, 60);
        check("b_first_bit", res_first_bit, 1'b1);
        check("b_steps", res_steps, 8);
        check("b_bits", res_bits, 16'h00FF);
        check("b_busy", res_busy, 40);
        check("b_done_at", res_done_at, 41);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.busy || bus.done) seen = 1;
        end
        check("b_no_retrigger", seen, 0);
        bus.start = 1'b0;
        repeat (2) tick();

        // zero length
        run_transfer(8'hAA, 4'd0, 1'b0, 10);
        check("c_done_at", res_done_at, 1);
        check("c_steps", res_steps, 0);
        check("c_busy", res_busy, 0);

        // 5 bits of 0xA5 -> 0,0,1,0,1
        run_transfer(8'hA5, 4'd5, 1'b0, 40);
        check("d_bits", res_bits, 16'b00101);
        check("d_done_at", res_done_at, 26);
        check("d_hold", res_hold_err, 0);

        // retrigger mid-transfer, then abort in the second strobe
        bus.pattern = 8'b0000_0101;
        bus.length  = 4'd3;
        bus.start   = 1'b1;
        seen = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.start = (k >= 3);
            if (bus.done) seen = 1;
            if (k == 7) begin
                check("e_step_before_abort", bus.step, 1'b1);
                bus.abort = 1'b1;
            end
            if (k == 8) check("e_abort_idle", outs(), 7'd0);
        end
        bus.abort = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.busy || bus.done) seen = 1;
        end
        check("e_no_done_no_restart", seen, 0);
        bus.start = 1'b0;
        repeat (2) tick();

        // reset during the gap of bit 2, then a full fresh transfer
        bus.pattern = 8'hC3;
        bus.length  = 4'd8;
        bus.start   = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            bus.start = 1'b0;
            if (k == 9) begin
                check("f_in_gap", bus.state_display, 3'd3);
                reset = 1'b0;
            end
            if (k == 10) check("f_reset_outputs", outs(), 7'd0);
        end
        reset = 1'b1;
        repeat (3) tick();
        run_transfer(8'hC3, 4'd8, 1'b0, 60);
        check("f_steps", res_steps, 8);
        check("f_bits", res_bits, 16'h00C3);
        check("f_done_at", res_done_at, 41);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_gen.md
# seq_gen

Bit-serial pattern transmitter that drives the `in`/`next` pair of the board-level sequence detector. On a `start` button edge it emits a latched pattern MSB-first. Each bit is held stable on `bit_out` while a `step` strobe is raised and then lowered, so the detector's registered edge logic consumes exactly one bit per strobe. It sits between the switch/button inputs and `seq_top` in the exam top level, replacing manual `next` pressing.

## Interface
- `HOLD_CYCLES`, default 2: cycles `step` is held high per bit (≥1).
- `GAP_CYCLES`, default 2: cycles `step` is low after each strobe (≥1).
- `MAX_LEN`, default 8: pattern register width in bits.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-low; `reset == 1'b0` at a rising `clk` clears all state.
- `start`, input, 1: level from a debounced button; only its rising edge matters.
- `abort`, input, 1: level; when high, returns the block to IDLE.
- `pattern`, input, MAX_LEN: bits to send; `pattern[len-1]` is sent first.
- `length`, input, 4: number of bits to send. 0 means no bits; values above MAX_LEN are clamped to MAX_LEN.
- `bit_out`, output, 1: serial data; drives the detector's `in`.
- `step`, output, 1: strobe; drives the detector's `next`.
- `busy`, output, 1: high from SETUP through the last GAP.
- `done`, output, 1: one-cycle pulse when a transfer completes.
- `state_display`, output, 3: current FSM encoding, for the LEDs.

## Operation
- States and encodings: IDLE=0, SETUP=1, STROBE=2, GAP=3, DONE=4.
- Start detection: `start_last` is registered every cycle in every state. The trigger is `start && !start_last`.
- IDLE:
  - On trigger, latch `pattern` into `pat_q` and the clamped `length` into `len_q`, and set `idx = len_q-1`.
  - If `len_q == 0`, go to DONE; otherwise go to SETUP.
  - A trigger in any other state is ignored.
- SETUP (1 cycle): `bit_out = pat_q[idx]`, `step = 0`. Then go to STROBE.
- STROBE (HOLD_CYCLES cycles): `step = 1`, `bit_out` unchanged. Then go to GAP.
- GAP (GAP_CYCLES cycles): `step = 0`, `bit_out` unchanged.
  - When the GAP count expires: if `idx == 0`, go to DONE; else decrement `idx` and go to SETUP.
- DONE (1 cycle): `done = 1`. Then go to IDLE.
- `bit_out` is 0 in IDLE and DONE. It changes only on SETUP entry, never while `step` is high.
- A single cycle counter (width $clog2(max(HOLD,GAP))+1) is reloaded on entry to STROBE and GAP.
- `abort`:
  - Highest priority after reset. From any state it forces IDLE on the next cycle, with `step` and `bit_out` 0 and no `done` pulse.
  - If `abort` and a trigger coincide in IDLE, `abort` wins.
- Reset values: state IDLE; `bit_out`, `step`, `busy`, `done`, `start_last` all 0; `state_display` 0.
- Reset asserted mid-transfer: all of the above apply on the next edge. A strobe in progress is truncated.

## Timing
- Trigger is seen in cycle T. SETUP is in T+1, and `step` first rises in T+2.
- Bit period is 1 + HOLD_CYCLES + GAP_CYCLES cycles; 5 with defaults.
- With N bits, `busy` is high for N·period cycles, starting at T+1.
- `done` is high in cycle T+1+N·period. IDLE resumes the cycle after that.
- For `length == 0`: `done` in T+1, no `step` activity.
- `bit_out` setup time before each `step` rise is ≥1 cycle. Hold time after each `step` fall is ≥GAP_CYCLES cycles.
- A `start` held high across the whole transfer does not retrigger.

## Structure
- `seq_pkg` holds:
  - the state localparams (IDLE…DONE), which `seq_top`'s display decode can share;
  - the `MAX_LEN` default;
  - the `length` width constant.
- Sub-module `edge_rise` (registered rising-edge detector with active-low sync reset) is used for `start`. It is also reusable for `seq_top`'s `next` handling.
- The FSM, counters and shift index stay in `seq_gen`.

## Test plan
- Reset: hold `reset=0` for 3 cycles with `start=1` → all outputs 0, `state_display=0`, and no transfer after reset is released while `start` stays high.
- `pattern=8'b0000_0010`, `length=3`, pulse `start` → `bit_out` sequence 0,1,0, with 3 `step` pulses each 2 cycles high. `done` comes 16 cycles after the trigger. A connected `seq_top` ends in STATE_3 with `out=1`.
- `pattern=8'hFF`, `length=12` → clamped to 8 bits: exactly 8 strobes, `busy` high for 40 cycles. The connected `seq_top` ends in STATE_6.
- `length=0` → `done` one cycle after the trigger, `step` never rises, `busy` stays 0.
- `start` retriggered mid-transfer, then `abort` asserted during the 2nd STROBE → retrigger ignored. The cycle after `abort` shows IDLE, `step=0`, and no `done` pulse.
- `reset=0` during a GAP of bit 2 → next cycle is IDLE with all outputs 0. A fresh `start` sends the full pattern from the MSB.
